// File: rtl/morse_pkg.sv
// morse_pkg
// Encodings and FSM state type shared by the morse receive and playback paths.
//   SYM_NONE / SYM_SHORT / SYM_LONG : 2-bit symbol codes used in the packed word
//   MAX_SYM                         : symbols per packed character
//   state_e                         : receiver FSM states
package morse_pkg;

    localparam logic [1:0] SYM_NONE  = 2'b00;
    localparam logic [1:0] SYM_SHORT = 2'b01;
    localparam logic [1:0] SYM_LONG  = 2'b10;

    localparam int unsigned MAX_SYM = 5;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        EMIT
    } state_e;

endpackage

// File: rtl/morse_receiver_debounce.sv
// debounce
// Two-flop synchronizer followed by a stability filter. The output only
// follows the synchronized input after it has differed from the output for
// DEB_CYC consecutive cycles.
//   clk   : system clock
//   reset : asynchronous active-low reset (output resets to 0 = released)
//   in    : raw asynchronous level
//   out   : synchronized, debounced level
module debounce #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int unsigned CW = $clog2(DEB_CYC) + 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        cnt_d   = '0;
        out_d   = out_q;
        // Any cycle where the input agrees with the output restarts the count.
        if (sync2_q != out_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/morse_receiver.sv
// morse_receiver
// Debounces the morse key, classifies presses as short/long by length,
// packs up to MAX_SYM symbols per character (slot 0 at [9:8]) and offers the
// finished word with a valid/ack handshake.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   key_n      : raw key, 0 = pressed, asynchronous
//   ack        : consumer accepts code (only meaningful while code_valid)
//   code       : packed character, 2 bits per slot
//   code_valid : code holds an unacknowledged character
//   overrun    : sticky, a character was dropped because code was still pending
//   busy       : a character is being assembled
module morse_receiver #(
    parameter int unsigned DEB_CYC  = 4,
    parameter int unsigned LONG_MIN = 20,
    parameter int unsigned GAP_CHAR = 40,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       ack,
    output logic [9:0] code,
    output logic       code_valid,
    output logic       overrun,
    output logic       busy
);

    import morse_pkg::*;

    logic key_raw;
    logic pressed;

    assign key_raw = ~key_n;

    debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .in   (key_raw),
        .out  (pressed)
    );

    state_e           state_q, state_d;
    logic             pressed_prev_q, pressed_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       nsym_q, nsym_d;
    logic [9:0]       asm_q, asm_d;
    logic [9:0]       code_q, code_d;
    logic             code_valid_q, code_valid_d;
    logic             overrun_q, overrun_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   press_len;
    logic [1:0]       sym;
    int unsigned      slot_lsb;

    assign rise = pressed & ~pressed_prev_q;
    assign fall = ~pressed & pressed_prev_q;

    always_comb begin
        state_d        = state_q;
        pressed_prev_d = pressed;
        cnt_d          = cnt_q;
        nsym_d         = nsym_q;
        asm_d          = asm_q;
        code_d         = code_q;
        code_valid_d   = code_valid_q;
        overrun_d      = overrun_q;

        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // One bit wider so a saturated counter still classifies as long.
        press_len = {1'b0, cnt_q} + 1'b1;
        sym       = (press_len < (CNT_W + 1)'(LONG_MIN)) ? SYM_SHORT : SYM_LONG;
        slot_lsb  = 2 * (MAX_SYM - 1 - 32'(nsym_q));

        if (code_valid_q && ack) begin
            code_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    asm_d[slot_lsb +: 2] = sym;
                    nsym_d               = nsym_q + 3'd1;
                    cnt_d                = '0;
                    state_d = (nsym_q == 3'(MAX_SYM - 1)) ? EMIT : GAP;
                end
            end
            GAP: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = PRESS;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(GAP_CHAR - 1)) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                // An ack in this same cycle frees the output for the new word.
                if (code_valid_q && !ack) begin
                    overrun_d = 1'b1;
                end else begin
                    code_d       = asm_q;
                    code_valid_d = 1'b1;
                end
                asm_d   = '0;
                nsym_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            pressed_prev_q <= 1'b0;
            cnt_q          <= '0;
            nsym_q         <= '0;
            asm_q          <= '0;
            code_q         <= '0;
            code_valid_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pressed_prev_q <= pressed_prev_d;
            cnt_q          <= cnt_d;
            nsym_q         <= nsym_d;
            asm_q          <= asm_d;
            code_q         <= code_d;
            code_valid_q   <= code_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver
// Self-checking bench for morse_receiver with directed scenarios and a
// randomized character stream checked against a press-length model.
module tb_morse_receiver;

    localparam int DEB_CYC  = 4;
    localparam int LONG_MIN = 20;
    localparam int GAP_CHAR = 40;
    localparam int CNT_W    = 16;
    localparam int SYNC_CYC = 2;
    localparam int NSLOT    = 5;
    // Negedges from the key release to the first sample showing code_valid.
    localparam int LAT_CHAR = SYNC_CYC + DEB_CYC + GAP_CHAR + 1;
    localparam int LAT_FULL = SYNC_CYC + DEB_CYC + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic       ack;
    logic [9:0] code;
    logic       code_valid;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    morse_receiver #(
        .DEB_CYC (DEB_CYC),
        .LONG_MIN(LONG_MIN),
        .GAP_CHAR(GAP_CHAR),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .ack       (ack),
        .code      (code),
        .code_valid(code_valid),
        .overrun   (overrun),
        .busy      (busy)
    );

    function automatic logic [9:0] model_code(input int lens[5], input int n);
        logic [9:0] c;
        c = '0;
        for (int i = 0; i < n; i++) begin
            c[9 - 2 * i -: 2] = (lens[i] >= LONG_MIN) ? 2'b10 : 2'b01;
        end
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int len);
        key_n = 1'b0;
        tick(len);
        key_n = 1'b1;
    endtask

    task automatic send_char(input int lens[5], input int gaps[5], input int n);
        for (int i = 0; i < n; i++) begin
            press(lens[i]);
            if (i < n - 1) tick(gaps[i]);
        end
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (code_valid !== 1'b1 && lat < budget) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_n = 1'($urandom_range(0, 1));
            tick(1);
            n_cmp++;
            if ({code, code_valid, overrun, busy} !== 13'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h expected 0", {code, code_valid, overrun, busy});
            end
        end
        key_n = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(10);
        n_cmp++;
        if ({code_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release: got %b expected 00", {code_valid, busy});
        end
    endtask

    task automatic test_short();
        int lens[5] = '{10, 0, 0, 0, 0};
        int lat;
        press(lens[0]);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL short_busy: got %b expected 1", busy);
        end
        wait_valid(200, lat);
        n_cmp++;
        if (lat != LAT_CHAR) begin
            n_bad++;
            $display("FAIL short_latency: got %0d expected %0d", lat, LAT_CHAR);
        end
        n_cmp++;
        if (code !== model_code(lens, 1) || code !== 10'b01_00_00_00_00) begin
            n_bad++;
            $display("FAIL short_code: got %b expected %b", code, 10'b01_00_00_00_00);
        end
        pulse_ack();
        n_cmp++;
        if (code_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL short_ack: got %b expected 0", code_valid);
        end
        // ack while nothing is pending must leave state untouched
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        n_cmp++;
        if ({code_valid, overrun, code} !== {2'b00, 10'b01_00_00_00_00}) begin
            n_bad++;
            $display("FAIL idle_ack: got %b expected %b", {code_valid, overrun, code},
                     {2'b00, 10'b01_00_00_00_00});
        end
        tick(5);
    endtask

    task automatic test_mixed();
        int lens[5] = '{30, 8, 30, 0, 0};
        int gaps[5] = '{15, 15, 0, 0, 0};
        int lat;
        send_char(lens, gaps, 3);
        wait_valid(200, lat);
        n_cmp++;
        if (code !== 10'b10_01_10_00_00 || lat != LAT_CHAR) begin
            n_bad++;
            $display("FAIL mixed: got code %b lat %0d expected %b lat %0d",
                     code, lat, 10'b10_01_10_00_00, LAT_CHAR);
        end
        pulse_ack();
        tick(5);
    endtask

    task automatic test_boundary();
        int lens[5] = '{LONG_MIN - 1, LONG_MIN, LONG_MIN + 1, 0, 0};
        int gaps[5] = '{12, 12, 0, 0, 0};
        int lat;
        send_char(lens, gaps, 3);
        wait_valid(200, lat);
        n_cmp++;
        if (code !== 10'b01_10_10_00_00) begin
            n_bad++;
            $display("FAIL boundary_code: got %b expected %b", code, 10'b01_10_10_00_00);
        end
        pulse_ack();
        tick(5);
    endtask

    task automatic test_glitch();
        logic seen;
        int   lat;
        seen = 1'b0;
        press(3);
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (busy !== 1'b0 || code_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_short_press: got activity %b expected 0", seen);
        end
        // 15 + 1 + 14 key cycles: the one-cycle release must be filtered out
        key_n = 1'b0;
        tick(15);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(14);
        key_n = 1'b1;
        wait_valid(200, lat);
        n_cmp++;
        if (code !== 10'b10_00_00_00_00 || lat != LAT_CHAR) begin
            n_bad++;
            $display("FAIL glitch_release: got code %b lat %0d expected %b lat %0d",
                     code, lat, 10'b10_00_00_00_00, LAT_CHAR);
        end
        pulse_ack();
        tick(5);
    endtask

    task automatic test_five();
        int lens[5] = '{8, 8, 8, 8, 8};
        int gaps[5] = '{10, 10, 10, 10, 10};
        int lat;
        send_char(lens, gaps, NSLOT);
        wait_valid(200, lat);
        n_cmp++;
        if (lat != LAT_FULL) begin
            n_bad++;
            $display("FAIL five_latency: got %0d expected %0d", lat, LAT_FULL);
        end
        n_cmp++;
        if (code !== 10'b01_01_01_01_01 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL five_code: got %b busy %b expected %b busy 0",
                     code, busy, 10'b01_01_01_01_01);
        end
        pulse_ack();
        tick(5);
    endtask

    task automatic test_ack_emit();
        int lat;
        press(10);
        wait_valid(200, lat);
        tick(3);
        press(30);
        tick(LAT_CHAR - 1);
        pulse_ack();
        n_cmp++;
        if ({code_valid, overrun, code} !== {2'b10, 10'b10_00_00_00_00}) begin
            n_bad++;
            $display("FAIL ack_in_emit: got %b expected %b", {code_valid, overrun, code},
                     {2'b10, 10'b10_00_00_00_00});
        end
        tick(1);
        n_cmp++;
        if (code_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_in_emit_hold: got %b expected 1", code_valid);
        end
        pulse_ack();
        n_cmp++;
        if (code_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_in_emit_clear: got %b expected 0", code_valid);
        end
        tick(5);
    endtask

    task automatic test_overrun();
        int lens[5] = '{30, 30, 0, 0, 0};
        int gaps[5] = '{10, 0, 0, 0, 0};
        int lat;
        press(10);
        wait_valid(200, lat);
        tick(3);
        send_char(lens, gaps, 2);
        tick(LAT_CHAR + 5);
        n_cmp++;
        if ({code_valid, overrun, code} !== {2'b11, 10'b01_00_00_00_00}) begin
            n_bad++;
            $display("FAIL overrun: got %b expected %b", {code_valid, overrun, code},
                     {2'b11, 10'b01_00_00_00_00});
        end
        pulse_ack();
        n_cmp++;
        if ({code_valid, overrun} !== 2'b01) begin
            n_bad++;
            $display("FAIL overrun_ack: got %b expected 01", {code_valid, overrun});
        end
        tick(5);
    endtask

    task automatic test_reset_mid();
        press(10);
        tick(10);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, code_valid, overrun, code} !== 13'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got %b expected 0", {busy, code_valid, overrun, code});
        end
        tick(2);
        reset = 1'b1;
        tick(LAT_CHAR + 20);
        n_cmp++;
        if ({busy, code_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_discard: got %b expected 00", {busy, code_valid});
        end
    endtask

    task automatic test_random();
        int         lens[5];
        int         gaps[5];
        int         n;
        int         lat;
        int         exp_lat;
        logic [9:0] exp_code;
        for (int c = 0; c < 12; c++) begin
            n = int'($urandom_range(1, NSLOT));
            for (int i = 0; i < NSLOT; i++) begin
                lens[i] = int'($urandom_range(DEB_CYC + 1, 45));
                gaps[i] = int'($urandom_range(DEB_CYC + 1, GAP_CHAR - 2));
            end
            exp_code = model_code(lens, n);
            exp_lat  = (n == NSLOT) ? LAT_FULL : LAT_CHAR;
            send_char(lens, gaps, n);
            wait_valid(200, lat);
            n_cmp++;
            if (code !== exp_code || lat != exp_lat) begin
                n_bad++;
                $display("FAIL random_char%0d: got code %b lat %0d expected %b lat %0d",
                         c, code, lat, exp_code, exp_lat);
            end
            tick(int'($urandom_range(0, 10)));
            n_cmp++;
            if (code_valid !== 1'b1 || code !== exp_code) begin
                n_bad++;
                $display("FAIL random_hold%0d: got valid %b code %b expected 1 %b",
                         c, code_valid, code, exp_code);
            end
            pulse_ack();
            n_cmp++;
            if (code_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL random_ack%0d: got %b expected 0", c, code_valid);
            end
            tick(DEB_CYC + 3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        key_n = 1'b1;
        ack   = 1'b0;
        reset = 1'b0;
        test_reset();
        test_short();
        test_mixed();
        test_boundary();
        test_glitch();
        test_five();
        test_ack_emit();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_receiver.md
# morse_receiver

Receiver end of the morse path. Samples the active-low push-button, debounces it and measures press and gap lengths to classify each press as short or long. Packs up to five symbols into the same 10-bit word format the playback path consumes. The word is offered to the CPU input-port logic with a valid/ack handshake.

## Interface
Parameters:
- DEB_CYC, 4: cycles the synchronized key must be stable before the debounced level changes.
- LONG_MIN, 20: press length in cycles at or above which a press is long. Shorter presses are short.
- GAP_CHAR, 40: released cycles that close the current character.
- CNT_W, 16: width of the press/gap counter. Saturates at all-ones.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: asynchronous, active-low reset.
- key_n, input, 1: raw button, 0 = pressed, asynchronous to clk.
- ack, input, 1: consumer accepts the word. Sampled only while code_valid=1.
- code, output, 10: packed character, 5 slots × 2 bits, slot 0 at [9:8]. 00 = empty, 01 = short, 10 = long, 11 never emitted.
- code_valid, output, 1: code holds a finished character.
- overrun, output, 1: sticky. A character finished while the previous one was still unacknowledged.
- busy, output, 1: a character is being assembled.

## Operation
- Input chain: key_n goes through a 2-FF synchronizer, then the debouncer. The result is `pressed`, which is 1 while the button is down.
- FSM states: IDLE, PRESS, GAP, EMIT.
  - IDLE: counter = 0. On a rising edge of `pressed`, go to PRESS and clear the counter.
  - PRESS: counter increments, saturating. On a falling edge of `pressed`:
    - Classify the press: counter+1 < LONG_MIN gives 01, otherwise 10.
    - Write the symbol into slot `nsym`, then increment nsym.
    - If nsym was 4 (fifth symbol), go to EMIT. Otherwise go to GAP and clear the counter.
  - GAP: counter increments.
    - A rising edge of `pressed` goes to PRESS and clears the counter.
    - If the counter reaches GAP_CHAR-1, go to EMIT.
  - EMIT: one cycle.
    - Copy the assembly register to code and set code_valid.
    - If code_valid was already 1 and ack is not asserted in this cycle, drop the new word, keep the old code, and set overrun.
    - Clear the assembly register and nsym, then go to IDLE.
- Handshake:
  - code_valid stays high until the cycle after ack=1 is sampled; it falls on that edge.
  - ack while code_valid=0 is ignored.
  - If ack and EMIT occur in the same cycle, the new word is loaded and code_valid stays 1. This does not count as an overrun.
- busy = (state ≠ IDLE).
- overrun clears only on reset.
- Presses shorter than DEB_CYC never reach the FSM.

## Timing
- Reset values: code=0, code_valid=0, overrun=0, busy=0. Synchronizer and debouncer registers reset to "released". FSM to IDLE, counter=0, nsym=0.
- Reset asserted mid-character discards the partial word with no emission.
- Edge latency: a key_n edge reaches `pressed` after 2 sync cycles plus DEB_CYC stable cycles.
- Press length is measured in `pressed` cycles, so debounce delay cancels out for classification.
- code_valid rises on the clock edge after the EMIT cycle. The EMIT cycle is entered GAP_CHAR cycles after the release edge seen by the FSM, or 1 cycle after the fifth release.
- A press held longer than 2^CNT_W-1 cycles is still classified long. The counter does not wrap.

## Structure
- Shared package morse_pkg holds:
  - The symbol encodings SYM_NONE=2'b00, SYM_SHORT=2'b01, SYM_LONG=2'b10.
  - The constant MAX_SYM=5.
  - The FSM state enum.
- The playback-side decomposition logic imports morse_pkg for the same encodings.
- One sub-module: debounce (parameter DEB_CYC; ports clk, reset, in, out). It contains the synchronizer and the stability counter.

## Test plan
All scenarios use the default parameters.
- Reset: hold reset=0 with key_n toggling. Required: all outputs 0, busy stays 0.
- One short press: 10-cycle press, then release. Required: code=10'b01_00_00_00_00, code_valid rises GAP_CHAR+1 cycles after `pressed` falls.
- Mixed character: presses of 30, 8, 30 cycles with 15-cycle gaps. Required: code=10'b10_01_10_00_00.
- Glitch rejection:
  - 3-cycle press: required no busy and no code_valid.
  - 1-cycle release inside a 30-cycle press: required a single long symbol.
- Five symbols: five 8-cycle presses with 10-cycle gaps. Required: code=10'b01_01_01_01_01, code_valid 2 cycles after the fifth `pressed` fall, no GAP_CHAR wait.
- Handshake and overrun:
  - Finish a character and hold ack=0, then finish a second character. Required: code unchanged, overrun=1.
  - Pulse ack. Required: code_valid falls next cycle.
  - Repeat with ack=1 in the EMIT cycle. Required: new code, code_valid stays 1, overrun unchanged.
